pipe_hazard_ctrl: RTL

Central stall/flush sequencer for the five-stage pipeline. Watches the ID-stage register reads, the ID/EX load destination, EX-stage redirects and the multi-cycle instruction/data memory handshakes. From these it drives the PC write enable plus the hold/flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also owns the memory-wait watchdog, the halt latch and a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_hazard_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Stall/flush sequencer for the five-stage pipeline. It drives the PC write
// enable and the hold/flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB
// registers. It also owns the data-memory wait watchdog, the halt latch and a
// saturating stall-cycle counter.
//
// Ports
//   clk                    rising-edge clock
//   rst                    asynchronous reset, active low
//   id_rs, id_rt           ID-stage source registers
//   id_rs_used, id_rt_used ID instruction actually reads that source
//   idex_mem_read, idex_rd load in ID/EX and its destination register
//   ex_redirect            EX resolved a taken branch/jump
//   imem_stall             instruction memory did not deliver this cycle
//   dmem_op, dmem_stall    MEM stage holds a memory op; data memory is busy
//   dmem_done              data memory access completes this cycle
//   wb_halt                HALT instruction is in WB
//   pc_we                  PC write enable
//   *_hold                 pipeline register keeps its value
//   ifid_flush, idex_flush register loads a NOP
//   halted, err            registered halt / watchdog status
//   stall_cycles           saturating count of cycles with pc_we low
module pipe_hazard_ctrl #(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       id_rs,
    input  logic [2:0]       id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             idex_mem_read,
    input  logic [2:0]       idex_rd,
    input  logic             ex_redirect,
    input  logic             imem_stall,
    input  logic             dmem_op,
    input  logic             dmem_stall,
    input  logic             dmem_done,
    input  logic             wb_halt,
    output logic             pc_we,
    output logic             ifid_hold,
    output logic             idex_hold,
    output logic             exmem_hold,
    output logic             memwb_hold,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DMEM_WAIT = 2'd1,
        HALTED    = 2'd2,
        ERR       = 2'd3
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_wait_cnt;
    logic             r_halted;
    logic             r_err;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_dmem_block;
    logic w_freeze;
    logic w_load_use;

    // A stall that completes in the same cycle is a single-cycle access and
    // does not freeze the pipeline.
    assign w_dmem_block = dmem_op & dmem_stall & ~dmem_done;

    assign w_freeze = ((r_state == RUN) & w_dmem_block)
                    | ((r_state == DMEM_WAIT) & ~dmem_done)
                    | (r_state == HALTED)
                    | (r_state == ERR);

    assign w_load_use = idex_mem_read &
                        ((id_rs_used & (id_rs == idex_rd)) |
                         (id_rt_used & (id_rt == idex_rd)));

    // Next-state logic. A halt is taken only when the pipeline is not frozen,
    // so a HALT seen during a memory wait is deferred until the wait ends.
    always_comb begin
        w_next = r_state;
        case (r_state)
            RUN: begin
                if (wb_halt & ~w_freeze)
                    w_next = HALTED;
                else if (w_dmem_block)
                    w_next = DMEM_WAIT;
            end
            DMEM_WAIT: begin
                if (wb_halt & ~w_freeze)
                    w_next = HALTED;
                else if (dmem_done)
                    w_next = RUN;
                else if (r_wait_cnt == WAIT_LAST)
                    w_next = ERR;
            end
            default: w_next = r_state;
        endcase
    end

    // Pipeline controls, highest-priority condition first.
    always_comb begin
        pc_we      = 1'b1;
        ifid_hold  = 1'b0;
        idex_hold  = 1'b0;
        exmem_hold = 1'b0;
        memwb_hold = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (w_freeze) begin
            pc_we      = 1'b0;
            ifid_hold  = 1'b1;
            idex_hold  = 1'b1;
            exmem_hold = 1'b1;
            memwb_hold = 1'b1;
        end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (w_load_use) begin
            pc_we      = 1'b0;
            ifid_hold  = 1'b1;
            idex_flush = 1'b1;
        end else if (imem_stall) begin
            pc_we      = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= RUN;
            r_wait_cnt  <= '0;
            r_halted    <= 1'b0;
            r_err       <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state  <= w_next;
            r_halted <= (w_next == HALTED);
            r_err    <= (w_next == ERR);
            if (r_state != DMEM_WAIT && w_next == DMEM_WAIT)
                r_wait_cnt <= '0;
            else if (r_state == DMEM_WAIT)
                r_wait_cnt <= r_wait_cnt + 8'd1;
            if (!pc_we && r_state != HALTED && r_state != ERR &&
                r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign halted       = r_halted;
    assign err          = r_err;
    assign stall_cycles = r_stall_cnt;

endmodule
